// File: rtl/group_add_sched_pkg.sv
// Shared definitions for the group adder scheduler.
// - state_t: controller states IDLE / RUN / DRAIN.
// - GROUP_ADD_LATENCY: pipeline depth of the four-way group adder. The
//   scheduler's valid pipe defaults to this value, so a change to the adder
//   is picked up here instead of being tracked by hand.
package group_add_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int GROUP_ADD_LATENCY = 5;

endpackage

// File: rtl/group_add_sched_if.sv
// Handshake bundle between the scheduler, the MAC array / group adder and
// the downstream consumer.
// - cfg_valid/cfg_ready/cfg_depth/cfg_count : job configuration
// - up_valid/up_ready                       : operand group gating into the adder
// - add_data                                : adder result (fixed latency after up_ready)
// - dn_data/dn_valid/dn_ready               : accumulated output stream
// slave  = scheduler side, master = environment side.
interface group_add_sched_if #(
  parameter int NUM_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CNT_WIDTH-1:0] cfg_depth;
  logic [CNT_WIDTH-1:0] cfg_count;
  logic                 up_valid;
  logic                 up_ready;
  logic [NUM_WIDTH-1:0] add_data;
  logic [NUM_WIDTH-1:0] dn_data;
  logic                 dn_valid;
  logic                 dn_ready;

  modport slave (
    input  cfg_valid, cfg_depth, cfg_count, up_valid, add_data, dn_ready,
    output cfg_ready, up_ready, dn_data, dn_valid
  );

  modport master (
    output cfg_valid, cfg_depth, cfg_count, up_valid, add_data, dn_ready,
    input  cfg_ready, up_ready, dn_data, dn_valid
  );
endinterface

// File: rtl/group_add_sched_fifo_sync.sv
// Synchronous FIFO, show-ahead (rdata is the head entry while !empty).
// Ports: clk, rst (sync, active-high, clears pointers/occupancy),
//        push/wdata, pop/rdata, full, empty.
// Push and pop in the same cycle are both honoured; when full, the pop
// frees the slot the push writes. When empty there is no bypass.
module group_add_sched_fifo_sync #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/group_add_sched.sv
// Group adder scheduler.
// Sequences operand groups into the fixed-latency group adder, tracks each
// issued group with a {valid, first, last} pipe aligned to add_data, sums
// `depth` consecutive adder results per output and queues outputs in a FIFO
// whose slots are reserved (credits) before the last group of an output issues.
// Ports: clk, rst (sync, active-high); bus (group_add_sched_if.slave:
//        cfg_*, up_*, add_data, dn_*); busy (state != IDLE);
//        done (one-cycle pulse after returning to IDLE).
module group_add_sched
  import group_add_sched_pkg::*;
#(
  parameter int NUM_WIDTH   = 16,
  parameter int ADD_LATENCY = GROUP_ADD_LATENCY,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst,
  group_add_sched_if.slave bus,
  output logic             busy,
  output logic             done
);
  localparam int CRW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] ONE    = CNT_WIDTH'(1);
  localparam logic [CRW-1:0]       CR_MAX = CRW'(FIFO_DEPTH);

  function automatic logic signed [NUM_WIDTH-1:0] wrap_add(
    input logic signed [NUM_WIDTH-1:0] a,
    input logic signed [NUM_WIDTH-1:0] b
  );
    return a + b;  // carry out dropped: wraps like the adder itself
  endfunction

  state_t                       state;
  logic [CNT_WIDTH-1:0]         depth_r;
  logic [CNT_WIDTH-1:0]         count_r;
  logic [CNT_WIDTH-1:0]         term;
  logic [CNT_WIDTH-1:0]         out_issued;
  logic [CRW-1:0]               credits;
  logic [ADD_LATENCY-1:0]       vld_p;
  logic [ADD_LATENCY-1:0]       first_p;
  logic [ADD_LATENCY-1:0]       last_p;
  logic signed [NUM_WIDTH-1:0]  acc;
  logic signed [NUM_WIDTH-1:0]  add_s;
  logic signed [NUM_WIDTH-1:0]  sum;
  logic last_term, issue, pop, push_p, tail_vld, tail_first, tail_last;
  logic fifo_full, fifo_empty, drain_clear;

  assign last_term    = (term == depth_r - ONE);
  // The reservation is only needed when the group completes an output.
  assign bus.up_ready = (state == ST_RUN) && (!last_term || (credits < CR_MAX));
  assign bus.cfg_ready = (state == ST_IDLE);
  assign busy         = (state != ST_IDLE);
  assign issue        = bus.up_valid && bus.up_ready;
  assign pop          = bus.dn_valid && bus.dn_ready;
  assign bus.dn_valid = !fifo_empty;

  // Leave DRAIN once nothing is in flight and the FIFO is empty or is
  // handing out its final entry this cycle, so done follows the last pop
  // by one cycle. In DRAIN credits equal FIFO occupancy.
  assign drain_clear = (vld_p == '0) &&
                       ((credits == '0) || ((credits == CRW'(1)) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      term       <= '0;
      out_issued <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cfg_valid) begin
            depth_r    <= (bus.cfg_depth == '0) ? ONE : bus.cfg_depth;
            count_r    <= bus.cfg_count;
            term       <= '0;
            out_issued <= '0;
            state      <= (bus.cfg_count == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            if (last_term) begin
              term       <= '0;
              out_issued <= out_issued + ONE;
              if (out_issued == count_r - ONE) state <= ST_DRAIN;
            end else begin
              term <= term + ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_clear) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= '0;
    end else begin
      case ({issue && last_term, pop})
        2'b10:   credits <= credits + CRW'(1);
        2'b01:   credits <= credits - CRW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // ---- p0 .. p(ADD_LATENCY-1): group tracking, tail aligned with add_data
  always_ff @(posedge clk) begin
    if (rst) vld_p <= '0;
    else     vld_p <= {vld_p[ADD_LATENCY-2:0], issue};
  end

  always_ff @(posedge clk) begin
    first_p <= {first_p[ADD_LATENCY-2:0], (term == '0)};
    last_p  <= {last_p[ADD_LATENCY-2:0], last_term};
  end

  // ---- pipe tail: accumulate and push completed outputs
  assign tail_vld   = vld_p[ADD_LATENCY-1];
  assign tail_first = first_p[ADD_LATENCY-1];
  assign tail_last  = last_p[ADD_LATENCY-1];
  assign add_s      = bus.add_data;
  assign sum        = tail_first ? add_s : wrap_add(acc, add_s);
  assign push_p     = tail_vld && tail_last;

  always_ff @(posedge clk) begin
    if (tail_vld) acc <= sum;
  end

  group_add_sched_fifo_sync #(
    .DATA_W (NUM_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_p),
    .pop   (pop),
    .wdata (sum),
    .rdata (bus.dn_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_p && fifo_full && !pop));

endmodule

// File: tb/tb_group_add_sched.sv
module tb_group_add_sched;
  import group_add_sched_pkg::*;

  localparam int L  = GROUP_ADD_LATENCY;
  localparam int FD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, done;

  group_add_sched_if #(.NUM_WIDTH(16), .CNT_WIDTH(16)) bus ();

  group_add_sched #(
    .NUM_WIDTH(16), .ADD_LATENCY(L), .FIFO_DEPTH(FD), .CNT_WIDTH(16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int pass_cnt = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Adder stand-in: the value of a group issued in cycle t appears on
  // add_data in cycle t+L; other cycles carry random junk.
  logic [15:0] dl [L];
  logic [15:0] nv;
  assign bus.add_data = dl[L-1];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    dl[0] <= nv;
    for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
  end

  // Reference model: outputs are sums of consecutive `depth` group values.
  int m_depth = 1, m_total = 0, m_issued = 0, outstanding = 0, max_out = 0;
  logic [15:0] m_sum;
  logic [15:0] exp_q[$];
  logic [15:0] val_q[$];
  logic [15:0] popped[$];
  int hs_cyc = 0, first_vcyc = -1, last_pcyc = 0, done_cyc = 0, done_cnt = 0;
  logic exp_ur, iss;

  always @(negedge clk) begin
    if (rst) begin
      m_total = 0; m_issued = 0; outstanding = 0; m_sum = '0;
      exp_q.delete(); val_q.delete();
      nv = 16'($urandom);
    end else begin
      exp_ur = (m_issued < m_total) &&
               (((m_issued % m_depth) != m_depth - 1) || (outstanding < FD));
      chk("up_ready", 32'(bus.up_ready), 32'(exp_ur));
      chk("cfg_ready_vs_busy", 32'(bus.cfg_ready), 32'(!busy));
      iss = bus.up_valid && bus.up_ready;
      nv = 16'($urandom);
      if (iss) begin
        if (val_q.size() > 0) nv = val_q.pop_front();
        m_sum = m_sum + nv;
        m_issued++;
        if ((m_issued % m_depth) == 0) begin
          exp_q.push_back(m_sum);
          m_sum = '0;
          outstanding++;
        end
      end
      if (outstanding > max_out) max_out = outstanding;
      if (bus.dn_valid) begin
        if (first_vcyc < 0) first_vcyc = cyc;
        if (exp_q.size() == 0) chk("dn_valid_spurious", 32'(bus.dn_valid), 32'd0);
        else begin
          chk("dn_data", 32'(bus.dn_data), 32'(exp_q[0]));
          if (bus.dn_ready) begin
            popped.push_back(bus.dn_data);
            void'(exp_q.pop_front());
            outstanding--;
            last_pcyc = cyc;
          end
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_complete", {30'd0, exp_q.size() == 0, m_issued == m_total}, 32'd3);
      end
      if (bus.cfg_valid && bus.cfg_ready) begin
        m_depth = (bus.cfg_depth == '0) ? 1 : int'(bus.cfg_depth);
        m_total = m_depth * int'(bus.cfg_count);
        m_issued = 0; m_sum = '0;
        hs_cyc = cyc; first_vcyc = -1;
        popped.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int d, input int c);
    int n = 0;
    bus.cfg_depth = 16'(d); bus.cfg_count = 16'(c); bus.cfg_valid = 1'b1;
    while (!bus.cfg_ready && n < 500) begin tick(); n++; end
    if (!bus.cfg_ready) chk("cfg_ready_timeout", 32'(bus.cfg_ready), 32'd1);
    tick();
    // Junk on cfg while the job runs: the latched configuration must rule.
    bus.cfg_valid = 1'b0;
    bus.cfg_depth = 16'($urandom); bus.cfg_count = 16'($urandom);
  endtask

  task automatic wait_done(input int lim, input int start_cnt);
    int n = 0;
    while (done_cnt == start_cnt && n < lim) begin tick(); n++; end
    tick();
    chk("done_pulses", 32'(done_cnt - start_cnt), 32'd1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, n, d, c;
    bus.cfg_valid = 1'b0; bus.cfg_depth = '0; bus.cfg_count = '0;
    bus.up_valid = 1'b0; bus.dn_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dn_valid", 32'(bus.dn_valid), 32'd0);
    chk("rst_up_ready", 32'(bus.up_ready), 32'd0);

    // depth=4 count=2, values 1..8 -> 10, 26
    for (int i = 1; i <= 8; i++) val_q.push_back(16'(i));
    bus.up_valid = 1'b1; bus.dn_ready = 1'b1;
    dc = done_cnt;
    start_job(4, 2);
    wait_done(200, dc);
    chk("t1_count", 32'(popped.size()), 32'd2);
    chk("t1_out0", 32'(popped[0]), 32'd10);
    chk("t1_out1", 32'(popped[1]), 32'd26);
    chk("t1_first_valid_lat", 32'(first_vcyc - hs_cyc), 32'd10);
    chk("t1_done_after_pop", 32'(done_cyc - last_pcyc), 32'd1);

    // depth=1 count=10 with downstream stalled: 8 credits, then release
    bus.dn_ready = 1'b0;
    dc = done_cnt;
    start_job(1, 10);
    repeat (30) tick();
    chk("t2_issued_blocked", 32'(m_issued), 32'd8);
    chk("t2_dn_valid_held", 32'(bus.dn_valid), 32'd1);
    chk("t2_up_ready_low", 32'(bus.up_ready), 32'd0);
    bus.dn_ready = 1'b1;
    wait_done(300, dc);
    chk("t2_count", 32'(popped.size()), 32'd10);

    // wrap: 0x7FFF + 1 + 1 = 0x8001
    val_q.push_back(16'h7FFF); val_q.push_back(16'h0001); val_q.push_back(16'h0001);
    dc = done_cnt;
    start_job(3, 1);
    wait_done(200, dc);
    chk("t3_wrap", 32'(popped[0]), 32'h8001);

    // reset two cycles after the third issue of a depth=4 job
    start_job(4, 2);
    n = 0;
    while (m_issued < 3 && n < 50) begin tick(); n++; end
    tick();
    rst = 1'b1; bus.up_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("t4_dn_valid", 32'(bus.dn_valid), 32'd0);
    chk("t4_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    val_q.push_back(16'd5); val_q.push_back(16'd6);
    bus.up_valid = 1'b1;
    dc = done_cnt;
    start_job(2, 1);
    wait_done(200, dc);
    chk("t4_count", 32'(popped.size()), 32'd1);
    chk("t4_fresh_sum", 32'(popped[0]), 32'd11);

    // count=0: no-op job
    dc = done_cnt;
    start_job(3, 0);
    wait_done(50, dc);
    chk("t5_done_lat", 32'(done_cyc - hs_cyc), 32'd2);

    // randomized gaps on both handshakes
    for (int j = 0; j < 40; j++) begin
      d = (j < 25) ? 5 : int'($urandom_range(0, 6));
      c = (j < 25) ? 20 : int'($urandom_range(0, 8));
      max_out = 0;
      dc = done_cnt;
      start_job(d, c);
      n = 0;
      while (done_cnt == dc && n < 6000) begin
        bus.up_valid = ($urandom_range(0, 9) < 7);
        bus.dn_ready = ($urandom_range(0, 9) < 6);
        tick();
        n++;
      end
      tick();
      chk("rand_done", 32'(done_cnt - dc), 32'd1);
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      chk("rand_credit_bound", 32'(max_out <= FD), 32'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
